// File: rtl/ipml_fifo_pkg.sv
// rtl/ipml_fifo_pkg.sv - shared constants and sizing helpers for the sync FIFO
package ipml_fifo_pkg;

  localparam int FIFO_MODE_STD  = 0;
  localparam int FIFO_MODE_FWFT = 1;

  function automatic int fifo_depth(input int width);
    return 1 << width;
  endfunction

  // Level must hold 0..depth inclusive, hence one extra bit.
  function automatic int fifo_level_width(input int width);
    return width + 1;
  endfunction

endpackage

// File: rtl/ipml_sync_fifo_fwft_if.sv
// rtl/ipml_sync_fifo_fwft_if.sv - handshake, data and status bundle of the sync FIFO
interface ipml_sync_fifo_fwft_if
  import ipml_fifo_pkg::*;
#(
  parameter int DW = 32,
  parameter int LW = fifo_level_width(10)
);
  logic          flush;
  logic [DW-1:0] wr_data;
  logic          wr_en;
  logic          wr_full;
  logic          almost_full;
  logic [DW-1:0] rd_data;
  logic          rd_en;
  logic          rd_empty;
  logic          almost_empty;
  logic [LW-1:0] water_level;
  logic          overflow;
  logic          underflow;

  modport master (
    output flush, wr_data, wr_en, rd_en,
    input  wr_full, almost_full, rd_data, rd_empty, almost_empty,
           water_level, overflow, underflow
  );

  modport slave (
    input  flush, wr_data, wr_en, rd_en,
    output wr_full, almost_full, rd_data, rd_empty, almost_empty,
           water_level, overflow, underflow
  );

endinterface

// File: rtl/ipml_sync_fifo_ram.sv
// rtl/ipml_sync_fifo_ram.sv - simple dual-port RAM with a one-cycle registered read
module ipml_sync_fifo_ram #(
  parameter int AW = 10,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic          re_i,
  input  logic [AW-1:0] raddr_i,
  output logic [DW-1:0] rdata_o
);

  logic [DW-1:0] mem_q [0:(1<<AW)-1];
  logic [DW-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Output register is resettable so the visible read data clears on rst/flush.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata_q <= '0;
    end else if (clr_i) begin
      rdata_q <= '0;
    end else if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/ipml_sync_fifo_fwft.sv
// rtl/ipml_sync_fifo_fwft.sv - single-clock FIFO with optional first-word-fall-through,
// flush, sticky error flags and a registered water level
module ipml_sync_fifo_fwft
  import ipml_fifo_pkg::*;
#(
  parameter int c_DEPTH_WIDTH      = 10,
  parameter int c_DATA_WIDTH       = 32,
  parameter int c_FWFT             = 0,
  parameter int c_ALMOST_FULL_NUM  = 1020,
  parameter int c_ALMOST_EMPTY_NUM = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  ipml_sync_fifo_fwft_if.slave fifo_if
);

  localparam int             LW    = fifo_level_width(c_DEPTH_WIDTH);
  localparam logic [LW-1:0]  DEPTH = LW'(fifo_depth(c_DEPTH_WIDTH));
  localparam logic [LW-1:0]  AF    = LW'(c_ALMOST_FULL_NUM);
  localparam logic [LW-1:0]  AE    = LW'(c_ALMOST_EMPTY_NUM);

  logic [c_DEPTH_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [c_DEPTH_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]            level_q, level_d;
  logic                     full_q, full_d;
  logic                     afull_q, afull_d;
  logic                     empty_q, empty_d;
  logic                     aempty_q, aempty_d;
  logic                     valid_q, valid_d;
  logic                     ovf_q, ovf_d;
  logic                     unf_q, unf_d;
  logic                     wr_acc, rd_acc, ram_we, ram_re;
  logic [LW-1:0]            ram_words;

  always_comb begin
    wr_acc    = fifo_if.wr_en & ~full_q;
    rd_acc    = fifo_if.rd_en & ~empty_q;
    ram_words = level_q - LW'(valid_q);
    ram_we    = wr_acc;
    if (c_FWFT == FIFO_MODE_FWFT) begin
      // Refill the output stage when it is empty or being popped this cycle.
      ram_re  = (~valid_q | rd_acc) & (ram_words != '0);
      valid_d = ram_re | (valid_q & ~rd_acc);
    end else begin
      ram_re  = rd_acc;
      valid_d = 1'b0;
    end
    wr_ptr_d = wr_ptr_q + c_DEPTH_WIDTH'(wr_acc);
    rd_ptr_d = rd_ptr_q + c_DEPTH_WIDTH'(ram_re);
    level_d  = level_q + LW'(wr_acc) - LW'(rd_acc);
    ovf_d    = ovf_q | (fifo_if.wr_en & full_q);
    unf_d    = unf_q | (fifo_if.rd_en & empty_q);

    if (fifo_if.flush) begin
      ram_we   = 1'b0;
      ram_re   = 1'b0;
      valid_d  = 1'b0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
      ovf_d    = 1'b0;
      unf_d    = 1'b0;
    end

    full_d   = (level_d == DEPTH);
    afull_d  = (level_d >= AF);
    aempty_d = (level_d <= AE);
    empty_d  = (c_FWFT == FIFO_MODE_FWFT) ? ~valid_d : (level_d == '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      full_q   <= 1'b0;
      afull_q  <= 1'b0;
      empty_q  <= 1'b1;
      aempty_q <= 1'b1;
      valid_q  <= 1'b0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      full_q   <= full_d;
      afull_q  <= afull_d;
      empty_q  <= empty_d;
      aempty_q <= aempty_d;
      valid_q  <= valid_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end

  // In FWFT mode the RAM output register doubles as the prefetch stage.
  ipml_sync_fifo_ram #(
    .AW (c_DEPTH_WIDTH),
    .DW (c_DATA_WIDTH)
  ) u_ram (
    .clk     (clk),
    .rst     (rst),
    .clr_i   (fifo_if.flush),
    .we_i    (ram_we),
    .waddr_i (wr_ptr_q),
    .wdata_i (fifo_if.wr_data),
    .re_i    (ram_re),
    .raddr_i (rd_ptr_q),
    .rdata_o (fifo_if.rd_data)
  );

  assign fifo_if.wr_full      = full_q;
  assign fifo_if.almost_full  = afull_q;
  assign fifo_if.rd_empty     = empty_q;
  assign fifo_if.almost_empty = aempty_q;
  assign fifo_if.water_level  = level_q;
  assign fifo_if.overflow     = ovf_q;
  assign fifo_if.underflow    = unf_q;

endmodule

// File: tb/tb_ipml_sync_fifo_fwft.sv
// tb/tb_ipml_sync_fifo_fwft.sv - standard and FWFT instances driven in lockstep against a queue model
module tb_ipml_sync_fifo_fwft;
  import ipml_fifo_pkg::*;

  localparam int AW = 4;
  localparam int DW = 8;
  localparam int LW = fifo_level_width(AW);
  localparam int DEPTH = fifo_depth(AW);
  localparam int AF_NUM = 14;
  localparam int AE_NUM = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  ipml_sync_fifo_fwft_if #(.DW(DW), .LW(LW)) fs ();
  ipml_sync_fifo_fwft_if #(.DW(DW), .LW(LW)) ff ();

  ipml_sync_fifo_fwft #(
    .c_DEPTH_WIDTH(AW), .c_DATA_WIDTH(DW), .c_FWFT(FIFO_MODE_STD),
    .c_ALMOST_FULL_NUM(AF_NUM), .c_ALMOST_EMPTY_NUM(AE_NUM)
  ) u_std (.clk(clk), .rst(rst), .fifo_if(fs));

  ipml_sync_fifo_fwft #(
    .c_DEPTH_WIDTH(AW), .c_DATA_WIDTH(DW), .c_FWFT(FIFO_MODE_FWFT),
    .c_ALMOST_FULL_NUM(AF_NUM), .c_ALMOST_EMPTY_NUM(AE_NUM)
  ) u_fwft (.clk(clk), .rst(rst), .fifo_if(ff));

  int total = 0;
  int bad = 0;

  // Model: queue of every stored word; vis = head word presented in FWFT mode.
  logic [DW-1:0] mq [2][$];
  bit            vis [2];
  bit            ovf [2];
  bit            unf [2];
  logic [DW-1:0] rdat [2];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      mq[m].delete();
      vis[m]  = 1'b0;
      ovf[m]  = 1'b0;
      unf[m]  = 1'b0;
      rdat[m] = '0;
    end
  endtask

  task automatic model_edge(input int m, input bit we, input bit re, input logic [DW-1:0] wd, input bit fl);
    int  sz;
    int  ram_words;
    bit  full, empty, wa, ra;
    if (fl) begin
      mq[m].delete();
      vis[m]  = 1'b0;
      ovf[m]  = 1'b0;
      unf[m]  = 1'b0;
      rdat[m] = '0;
      return;
    end
    sz    = mq[m].size();
    full  = (sz == DEPTH);
    empty = (m == 0) ? (sz == 0) : !vis[m];
    wa    = we && !full;
    ra    = re && !empty;
    if (we && full)  ovf[m] = 1'b1;
    if (re && empty) unf[m] = 1'b1;
    if (m == 0) begin
      if (ra) rdat[0] = mq[0].pop_front();
    end else begin
      ram_words = sz - int'(vis[1]);
      if (ra) void'(mq[1].pop_front());
      vis[1] = (vis[1] && !ra) || (ram_words > 0);
    end
    if (wa) mq[m].push_back(wd);
  endtask

  task automatic compare_all();
    for (int m = 0; m < 2; m++) begin
      string p;
      int    sz;
      logic [LW-1:0] lvl;
      logic [DW-1:0] rd;
      logic fu, af, em, ae, ov, un;
      p  = (m == 0) ? "std" : "fwft";
      sz = mq[m].size();
      if (m == 0) begin
        lvl = fs.water_level; rd = fs.rd_data; fu = fs.wr_full; af = fs.almost_full;
        em = fs.rd_empty; ae = fs.almost_empty; ov = fs.overflow; un = fs.underflow;
      end else begin
        lvl = ff.water_level; rd = ff.rd_data; fu = ff.wr_full; af = ff.almost_full;
        em = ff.rd_empty; ae = ff.almost_empty; ov = ff.overflow; un = ff.underflow;
      end
      check_eq({p, "_level"}, 32'(lvl), 32'(sz));
      check_eq({p, "_full"}, 32'(fu), 32'(sz == DEPTH));
      check_eq({p, "_almost_full"}, 32'(af), 32'(sz >= AF_NUM));
      check_eq({p, "_almost_empty"}, 32'(ae), 32'(sz <= AE_NUM));
      check_eq({p, "_empty"}, 32'(em), 32'((m == 0) ? (sz == 0) : !vis[m]));
      check_eq({p, "_overflow"}, 32'(ov), 32'(ovf[m]));
      check_eq({p, "_underflow"}, 32'(un), 32'(unf[m]));
      if (m == 0) begin
        check_eq({p, "_rd_data"}, 32'(rd), 32'(rdat[0]));
      end else if (vis[1]) begin
        check_eq({p, "_rd_data"}, 32'(rd), 32'(mq[1][0]));
      end
    end
  endtask

  task automatic cyc(input bit we, input bit re, input logic [DW-1:0] wd, input bit fl);
    fs.wr_en = we; fs.rd_en = re; fs.wr_data = wd; fs.flush = fl;
    ff.wr_en = we; ff.rd_en = re; ff.wr_data = wd; ff.flush = fl;
    @(posedge clk);
    model_edge(0, we, re, wd, fl);
    model_edge(1, we, re, wd, fl);
    #1;
    compare_all();
  endtask

  initial begin
    int wp, rp;
    logic [DW-1:0] d;
    fs.wr_en = 1'b0; fs.rd_en = 1'b0; fs.wr_data = '0; fs.flush = 1'b0;
    ff.wr_en = 1'b0; ff.rd_en = 1'b0; ff.wr_data = '0; ff.flush = 1'b0;
    model_reset();
    #2 rst = 1'b1;
    #1 compare_all();
    @(negedge clk);
    #2 rst = 1'b0;

    // Fill to full, then one rejected write.
    for (int i = 0; i < DEPTH; i++) cyc(1'b1, 1'b0, DW'(i), 1'b0);
    check_eq("std_full_at_16", 32'(fs.wr_full), 32'd1);
    cyc(1'b1, 1'b0, 8'hFF, 1'b0);
    check_eq("std_overflow_17th", 32'(fs.overflow), 32'd1);
    for (int i = 0; i < DEPTH; i++) cyc(1'b0, 1'b1, 8'h00, 1'b0);
    check_eq("std_last_drained", 32'(fs.rd_data), 32'h0F);

    // Underflow on empty, stays sticky through normal traffic.
    cyc(1'b0, 1'b1, 8'h00, 1'b0);
    check_eq("std_underflow_set", 32'(fs.underflow), 32'd1);
    cyc(1'b1, 1'b0, 8'h3C, 1'b0);
    cyc(1'b0, 1'b0, 8'h00, 1'b0);
    cyc(1'b0, 1'b1, 8'h00, 1'b0);
    cyc(1'b0, 1'b0, 8'h00, 1'b0);

    // Flush at level 10 with overflow already set and both requests high.
    for (int i = 0; i < 10; i++) cyc(1'b1, 1'b0, DW'(8'h40 + i), 1'b0);
    cyc(1'b1, 1'b1, 8'hEE, 1'b1);
    check_eq("std_flush_rd_data", 32'(fs.rd_data), 32'h0);
    check_eq("fwft_flush_level", 32'(ff.water_level), 32'h0);

    // FWFT latency with a single word.
    cyc(1'b1, 1'b0, 8'hA5, 1'b0);
    check_eq("fwft_lat_empty_k1", 32'(ff.rd_empty), 32'd1);
    cyc(1'b0, 1'b0, 8'h00, 1'b0);
    check_eq("fwft_lat_data_k2", 32'(ff.rd_data), 32'hA5);
    cyc(1'b0, 1'b1, 8'h00, 1'b0);
    cyc(1'b0, 1'b0, 8'h00, 1'b0);

    // Concurrent streaming at level 8, wrapping both pointers.
    for (int i = 0; i < 8; i++) cyc(1'b1, 1'b0, DW'(i), 1'b0);
    cyc(1'b0, 1'b0, 8'h00, 1'b0);
    for (int i = 8; i < 48; i++) cyc(1'b1, 1'b1, DW'(i), 1'b0);

    // Asynchronous reset between edges at level 5.
    cyc(1'b1, 1'b0, 8'h00, 1'b1);
    for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0, DW'(8'h90 + i), 1'b0);
    fs.wr_en = 1'b0; ff.wr_en = 1'b0;
    #3 rst = 1'b1;
    #1;
    model_reset();
    compare_all();
    #2 rst = 1'b0;
    cyc(1'b1, 1'b0, 8'h5A, 1'b0);
    cyc(1'b0, 1'b0, 8'h00, 1'b0);
    cyc(1'b0, 1'b1, 8'h00, 1'b0);
    check_eq("std_after_reset_data", 32'(fs.rd_data), 32'h5A);

    // Randomized traffic with varying write/read pressure and rare flushes.
    for (int ph = 0; ph < 6; ph++) begin
      case (ph % 3)
        0: begin wp = 80; rp = 30; end
        1: begin wp = 30; rp = 80; end
        default: begin wp = 60; rp = 60; end
      endcase
      for (int i = 0; i < 300; i++) begin
        d = DW'($urandom);
        cyc($urandom_range(0, 99) < wp, $urandom_range(0, 99) < rp, d,
            $urandom_range(0, 149) == 0);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
